// File: rtl/d_redu_pipe.sv
// Three-stage pipelined reduction of 46-bit products mod Dq = 2^23 - 2^13 + 1,
// multi-lane with one shared valid/ready handshake and a sideband tag.
module d_redu_pipe #(
  parameter int LANES    = 1,
  parameter int TAG_W    = 4,
  parameter int CENTERED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [48*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [23*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic [LANES-1:0]      out_err
);

  localparam logic [23:0] DQ24 = 24'd8380417;
  localparam logic [22:0] DQ23 = 23'd8380417;
  localparam logic [22:0] HALF = 23'd4190208;

  // Handshake: a beat moves on an edge where valid & ready are both high.
  // The whole pipe advances as one (w_adv) whenever the output slot is empty
  // or being drained, so in_ready is combinational from out_ready.
  logic             w_adv;
  logic             r_v1, r_v2, r_v3;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;

  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign out_tag   = r_tag3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_tag1 <= in_tag;
      r_tag2 <= r_tag1;
      r_tag3 <= r_tag2;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [47:0] w_x;
    logic        w_err;
    logic [36:0] w_t;
    logic [27:0] w_u;
    logic [23:0] w_v;
    logic [22:0] w_r;
    logic [22:0] w_o;
    logic [36:0] r_t1;
    logic [27:0] r_u2;
    logic [22:0] r_d3;
    logic        r_e1, r_e2, r_e3;

    assign w_x   = in_data[48*g +: 48];
    assign w_err = |w_x[47:46];

    // Each fold rewrites hi*2^23 + lo as hi*2^13 - hi + lo; hi*2^13 >= hi keeps it non-negative.
    assign w_t = {1'b0, w_x[45:23], 13'd0} + {14'd0, w_x[22:0]} - {14'd0, w_x[45:23]};
    assign w_u = {1'b0, r_t1[36:23], 13'd0} + {5'd0, r_t1[22:0]} - {14'd0, r_t1[36:23]};
    // Third fold leaves w_v < 2^23 + 2^18 < 2*Dq, so one conditional subtract is exact.
    assign w_v = {6'd0, r_u2[27:23], 13'd0} + {1'b0, r_u2[22:0]} - {19'd0, r_u2[27:23]};

    always_comb begin
      w_r = w_v[22:0];
      if (w_v >= DQ24) w_r = w_v[22:0] - DQ23;
      w_o = w_r;
      if (CENTERED != 0 && w_r > HALF) w_o = w_r - DQ23;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_t1 <= '0;
        r_u2 <= '0;
        r_d3 <= '0;
        r_e1 <= 1'b0;
        r_e2 <= 1'b0;
        r_e3 <= 1'b0;
      end else if (w_adv) begin
        r_t1 <= w_t;
        r_e1 <= w_err;
        r_u2 <= w_u;
        r_e2 <= r_e1;
        r_d3 <= r_e2 ? 23'd0 : w_o;
        r_e3 <= r_e2;
      end
    end

    assign out_data[23*g +: 23] = r_d3;
    assign out_err[g]           = r_e3;
  end

endmodule

// File: tb/tb_d_redu_pipe.sv
// Bench for d_redu_pipe: two 4-lane instances (plain and centered) share stimulus;
// a scoreboard compares every emitted beat against a % based reference.
module tb_d_redu_pipe;
  localparam int LANES = 4;
  localparam int TAG_W = 4;
  localparam int DW    = 48*LANES;
  localparam int OW    = 23*LANES;
  localparam int QW    = TAG_W + DW;
  localparam longint unsigned DQ = 64'd8380417;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_ready = 1'b1;
  logic             in_ready, in_ready_c;
  logic             out_valid, out_valid_c;
  logic [OW-1:0]    out_data, out_data_c;
  logic [TAG_W-1:0] out_tag, out_tag_c;
  logic [LANES-1:0] out_err, out_err_c;

  d_redu_pipe #(.LANES(LANES), .TAG_W(TAG_W), .CENTERED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );

  d_redu_pipe #(.LANES(LANES), .TAG_W(TAG_W), .CENTERED(1)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_data(out_data_c), .out_tag(out_tag_c), .out_err(out_err_c)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [22:0] ref_lane(input logic [47:0] x, input bit cen);
    longint unsigned r;
    if (x[47:46] != 2'b00) return 23'd0;
    r = {16'd0, x} % DQ;
    if (cen && r > (DQ - 1) / 2) r = r - DQ;
    return r[22:0];
  endfunction

  function automatic logic [OW-1:0] ref_data(input logic [DW-1:0] d, input bit cen);
    logic [OW-1:0] o = '0;
    for (int i = 0; i < LANES; i++) o[23*i +: 23] = ref_lane(d[48*i +: 48], cen);
    return o;
  endfunction

  function automatic logic [LANES-1:0] ref_err(input logic [DW-1:0] d);
    logic [LANES-1:0] e = '0;
    for (int i = 0; i < LANES; i++) e[i] = (d[48*i+46 +: 2] != 2'b00);
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q[$];
  int            acc_q[$];
  bit            chk_lat = 1'b1;
  bit            prev_stall = 1'b0;
  logic [OW-1:0]    prev_data, prev_data_c;
  logic [TAG_W-1:0] prev_tag;
  logic [LANES-1:0] prev_err;
  logic [QW-1:0]    sb_e;
  int               sb_a;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      check_eq("rst_out_valid", {out_valid_c, out_valid}, 0);
      check_eq("rst_out_data", {out_data_c, out_data}, 0);
      check_eq("rst_out_tag_err", {out_tag, out_err}, 0);
      if (!rst) check_eq("in_ready_after_rst", {in_ready_c, in_ready}, 2'b11);
      prev_stall = 1'b0;
    end else if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check_eq("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check_eq("stall_data", out_data, prev_data);
        check_eq("stall_data_c", out_data_c, prev_data_c);
        check_eq("stall_tag_err", {out_tag, out_err}, {prev_tag, prev_err});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out_valid", 1, 0);
        end else begin
          sb_e = exp_q.pop_front();
          sb_a = acc_q.pop_front();
          check_eq("data", out_data, ref_data(sb_e[DW-1:0], 1'b0));
          check_eq("data_centered", out_data_c, ref_data(sb_e[DW-1:0], 1'b1));
          check_eq("tag", out_tag, sb_e[QW-1:DW]);
          check_eq("err", out_err, ref_err(sb_e[DW-1:0]));
          check_eq("valid_c", out_valid_c, 1'b1);
          if (chk_lat) check_eq("latency", cyc - sb_a, 3);
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_data_c = out_data_c;
      prev_tag    = out_tag;
      prev_err    = out_err;
    end
  end

  // ---------------- drivers ----------------
  int mode = 0;  // 0: ready, 1: ready 1-of-3, 2: random, 3: stalled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [TAG_W-1:0] t);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 0, 1);
    else begin
      exp_q.push_back({t, d});
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rand_x(input bit allow_bad);
    logic [63:0] v;
    v = {$urandom, $urandom};
    if (allow_bad && $urandom_range(0, 15) == 0) return {2'b11 ^ 2'($urandom_range(0, 2)), v[45:0]};
    case ($urandom_range(0, 9))
      0:       return 48'd0;
      1:       return 48'(DQ - 1);
      2:       return 48'(DQ);
      3:       return 48'h3FFF_FFFF_FFFF;
      default: return {2'b00, v[45:0]};
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_beat(input bit allow_bad);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) d[48*i +: 48] = rand_x(allow_bad);
    return d;
  endfunction

  // ---------------- tests ----------------
  logic [DW-1:0] d;
  logic [47:0]   t2_vals[3];
  logic [47:0]   t3_vals[3];

  initial begin
    t2_vals = '{48'd8380417, 48'd70231389093888, 48'h3FFF_FFFF_FFFF};
    t3_vals = '{48'd8380416, 48'd4190208, 48'd4190209};

    // Test 1: two reset cycles, then 2^23 on lane 0.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d = rand_beat(1'b0);
    d[47:0] = 48'h0000_0080_0000;
    send(d, 4'd1);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    check_eq("t1_lane0", out_data[22:0], 23'd8191);
    check_eq("t1_err", out_err, 0);
    drain();

    // Test 2: exact boundary values back-to-back.
    for (int i = 0; i < 3; i++) begin
      d = rand_beat(1'b0);
      d[47:0] = t2_vals[i];
      send(d, 4'(i + 2));
    end
    drain();

    // Test 3: centering thresholds on every lane.
    for (int i = 0; i < 3; i++) begin
      d = '0;
      for (int l = 0; l < LANES; l++) d[48*l +: 48] = t3_vals[i];
      send(d, 4'(i + 5));
    end
    drain();
    check_eq("t3_lane0_last", out_data_c[22:0], 23'h401000);

    // Test 4: 16 tagged beats under 1-of-3 ready.
    chk_lat = 1'b0;
    mode = 1;
    for (int i = 0; i < 16; i++) send(rand_beat(1'b0), 4'(i));
    drain();
    mode = 0;
    idle(2);

    // Test 5: illegal operand on lane 2 only.
    chk_lat = 1'b1;
    d = rand_beat(1'b0);
    d[48*2 +: 48] = 48'hC000_0000_0000;
    send(d, 4'd9);
    drain();
    check_eq("t5_err", out_err, 4'b0100);
    check_eq("t5_lane2", out_data[46 +: 23], 23'd0);

    // Test 6: reset with three beats stuck in the pipe.
    mode = 3;
    idle(2);
    for (int i = 0; i < 3; i++) send(rand_beat(1'b0), 4'(10 + i));
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 mode = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    send(rand_beat(1'b0), 4'd13);
    drain();

    // Test 7: random operands, gaps and back-pressure.
    chk_lat = 1'b0;
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      send(rand_beat(1'b1), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
